ev19_soc_led_pio: RTL and testbench

Avalon-MM output parallel port driving the board LEDs. It is the write-direction counterpart of the SoC's input PIO for the DIP switches. Software writes a data register, atomic set/clear registers, and a per-bit blink mask. A free-running blink timer toggles the masked bits autonomously. The block sits on the EV19 SoC peripheral bus with the other PIO slaves, and its out_port goes to the LED pins.

---
 rtl/ev19_soc_pio_pkg.sv | 17 +
 rtl/ev19_soc_blink_timer.sv | 32 +++
 rtl/ev19_soc_led_pio.sv | 88 ++++++++
 tb/tb_ev19_soc_led_pio.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ev19_soc_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ev19_soc_pio_pkg
// Purpose : Shared register map for the EV19 SoC parallel I/O slaves.
// Rev     : 1.0  initial release
// ============================================================================
package ev19_soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

endpackage
`default_nettype wire

// File: rtl/ev19_soc_blink_timer.sv
`default_nettype none
// ============================================================================
// Module  : ev19_soc_blink_timer
// Purpose : Free-running divider; phase toggles once every `period` cycles.
//           A zero period parks the timer; restart zeroes count and phase.
// Rev     : 1.0  initial release
// ============================================================================
module ev19_soc_blink_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] period,
  input  logic        restart,
  output logic        phase
);

  logic [31:0] cnt;

  // Count up to period-1, then wrap and flip the phase.
  always_ff @(posedge clk) begin
    if (reset || restart || (period == 32'd0)) begin
      cnt   <= 32'd0;
      phase <= 1'b0;
    end else if (cnt == (period - 32'd1)) begin
      cnt   <= 32'd0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ev19_soc_led_pio.sv
`default_nettype none
// ============================================================================
// Module  : ev19_soc_led_pio
// Purpose : Avalon-MM output PIO for the board LEDs with atomic set/clear
//           registers and a per-bit hardware blink mask.
// Rev     : 1.0  initial release
// ============================================================================
module ev19_soc_led_pio
  import ev19_soc_pio_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [31:0]      PERIOD_RESET = 32'd25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] mask;
  logic [31:0]      period;
  logic             phase;
  logic             wr_en;
  logic             period_wr;
  logic [31:0]      rd_next;

  assign wr_en     = chipselect & ~write_n;
  assign period_wr = wr_en && (address == ADDR_PERIOD);

  // Register file; only one bus write per cycle, so set/clear never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= RESET_VALUE;
      mask   <= '0;
      period <= PERIOD_RESET;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data   <= writedata[WIDTH-1:0];
        ADDR_MASK:   mask   <= writedata[WIDTH-1:0];
        ADDR_PERIOD: period <= writedata;
        ADDR_OUTSET: data   <= data | writedata[WIDTH-1:0];
        ADDR_OUTCLR: data   <= data & ~writedata[WIDTH-1:0];
        default:     ;
      endcase
    end
  end

  // Blink timer is restarted by any PERIOD write, even an unchanged value.
  ev19_soc_blink_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .period  (period),
    .restart (period_wr),
    .phase   (phase)
  );

  // LED drive is purely a function of flops; bus inputs never reach it.
  assign out_port = data ^ (mask & {WIDTH{phase}});

  // Read mux; write-only and reserved locations return zero.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:   rd_next[WIDTH-1:0] = data;
      ADDR_MASK:   rd_next[WIDTH-1:0] = mask;
      ADDR_PERIOD: rd_next            = period;
      ADDR_STATUS: rd_next[WIDTH-1:0] = out_port;
      default:     rd_next            = '0;
    endcase
  end

  // Read data is captured every cycle, independent of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ev19_soc_led_pio.sv
`default_nettype none
// ============================================================================
// Module  : tb_ev19_soc_led_pio
// Purpose : Directed bench for the LED PIO (WIDTH=4, RESET_VALUE=4'hA).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ev19_soc_led_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int n_vec = 0;
  int n_err = 0;

  ev19_soc_led_pio #(
    .WIDTH        (4),
    .RESET_VALUE  (4'hA),
    .PERIOD_RESET (32'd25_000_000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus tasks are entered at a negedge and return at the next negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  function automatic logic [3:0] blink_out(input int k, input int per, input logic [3:0] d, input logic [3:0] m);
    logic ph;
    ph = ((k / per) % 2) == 1;
    return d ^ (m & {4{ph}});
  endfunction

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    //             cs    wr    addr  wdata          out   rd
    vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'd0,         4'hA, 32'd25_000_000};
    vecs[1]  = '{1'b1, 1'b1, 3'd0, 32'h5,         4'h5, 32'hA};
    vecs[2]  = '{1'b1, 1'b1, 3'd4, 32'h8,         4'hD, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 3'd5, 32'h1,         4'hC, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 32'd0,         4'hC, 32'hC};
    vecs[5]  = '{1'b1, 1'b0, 3'd3, 32'd0,         4'hC, 32'hC};
    vecs[6]  = '{1'b1, 1'b0, 3'd6, 32'd0,         4'hC, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'd7, 32'd0,         4'hC, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 3'd6, 32'hF,         4'hC, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'h0,         4'hC, 32'hC};
    vecs[10] = '{1'b1, 1'b1, 3'd1, 32'h3,         4'hC, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'd1, 32'd0,         4'hC, 32'h3};
    vecs[12] = '{1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 32'hC};
    vecs[13] = '{1'b1, 1'b0, 3'd0, 32'd0,         4'hF, 32'hF};
    vecs[14] = '{1'b1, 1'b1, 3'd1, 32'h0,         4'hF, 32'h3};
    vecs[15] = '{1'b1, 1'b1, 3'd0, 32'h0,         4'h0, 32'hF};

    // Reset for two cycles
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_out", {28'd0, out_port}, 32'hA);
    check("reset_rd", readdata, 32'h0);

    // Table: drive one cycle, check the LED and registered read after it
    for (int i = 0; i < 16; i++) begin
      chipselect = vecs[i].cs;
      write_n    = ~vecs[i].wr;
      address    = vecs[i].addr;
      writedata  = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d_out", i), {28'd0, out_port}, {28'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Blink at PERIOD=4 with mask 3 over DATA=0; STATUS reads lag by one
    bus_write(3'd1, 32'h3);
    bus_write(3'd2, 32'd4);
    address = 3'd3;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("blink_out_k%0d", k), {28'd0, out_port}, {28'd0, blink_out(k, 4, 4'h0, 4'h3)});
      check($sformatf("blink_status_k%0d", k), readdata, {28'd0, blink_out(k - 1, 4, 4'h0, 4'h3)});
    end

    // Rewriting the same PERIOD mid-count restarts the timer
    bus_write(3'd2, 32'd10);
    repeat (6) @(negedge clk);
    bus_write(3'd2, 32'd10);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("restart_k%0d", k), {28'd0, out_port}, {28'd0, (k >= 10) ? 4'h3 : 4'h0});
    end

    // PERIOD=0 parks phase at 0 so out_port follows DATA
    bus_write(3'd2, 32'd0);
    check("period0_out", {28'd0, out_port}, 32'h0);
    bus_write(3'd0, 32'h5);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("period0_hold_k%0d", k), {28'd0, out_port}, 32'h5);
    end

    // Reset while phase=1 together with a DATA write
    bus_write(3'd2, 32'd4);
    repeat (5) @(negedge clk);
    check("pre_reset_blink", {28'd0, out_port}, 32'h6);
    reset      = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'hF;
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("reset_mid_out", {28'd0, out_port}, 32'hA);
    check("reset_mid_rd", readdata, 32'h0);
    // Mask back on: phase must have been cleared, and the period restored
    bus_write(3'd1, 32'h3);
    address = 3'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_phase_k%0d", k), {28'd0, out_port}, 32'hA);
    end
    check("post_reset_period", readdata, 32'd25_000_000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
